// File: rtl/axi_pkg.sv
// axi_pkg: definitions shared by the AXI3 slave-side blocks.
//   - Burst type encodings (AWBURST/ARBURST).
//   - Response encodings (BRESP/RRESP).
//   - Write-slave FSM state encoding.
//   - resp_merge(): keeps the more severe of two responses.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wr_state_e;

    // The encodings are ordered by severity (DECERR > SLVERR > OKAY),
    // so the more severe response is simply the larger value.
    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address for an AXI3 burst.
//   cur_addr  in  32  address of the current beat
//   awsize    in  3   log2 bytes per beat
//   awlen     in  4   beats minus 1
//   awburst   in  2   FIXED / INCR / WRAP (reserved treated as INCR)
//   next_addr out 32  address of the following beat
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  logic [31:0] cur_addr,
    input  logic [2:0]  awsize,
    input  logic [3:0]  awlen,
    input  logic [1:0]  awburst,
    output logic [31:0] next_addr
);

    logic [31:0] incr_bytes;
    logic [31:0] wrap_bytes;
    logic [31:0] wrap_mask;
    logic [31:0] stepped;

    always_comb begin
        incr_bytes = 32'd1 << awsize;
        wrap_bytes = ({28'd0, awlen} + 32'd1) << awsize;
        wrap_mask  = wrap_bytes - 32'd1;
        stepped    = cur_addr + incr_bytes;
        case (awburst)
            BURST_FIXED: next_addr = cur_addr;
            // Upper bits stay on the aligned block base, lower bits roll over.
            BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) | (stepped & wrap_mask);
            default:     next_addr = stepped;
        endcase
    end

endmodule

// File: rtl/axi_write_slave.sv
// axi_write_slave: AXI3 write-channel responder backed by a word memory.
// Accepts one AW transaction at a time, absorbs its W burst into memory
// under byte strobes, then returns a B response. A registered device-side
// read port exposes the stored words.
//   devclock, ARESETn                clock, synchronous active-low reset
//   AW* (AWID..AWVALID) / AWREADY    write address channel
//   W*  (WID..WVALID)   / WREADY     write data channel
//   BID, BRESP, BVALID  / BREADY     write response channel
//   rd_addr / rd_data                word index in, registered data out
module axi_write_slave
    import axi_pkg::*;
#(
    parameter int buswidth = 32,
    parameter int MEMDEPTH = 64,
    parameter int AW_IDX   = 6
) (
    input  logic                devclock,
    input  logic                ARESETn,
    input  logic [3:0]          AWID,
    input  logic [31:0]         AWADDR,
    input  logic [3:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic [1:0]          AWLOCK,
    input  logic [3:0]          AWCACHE,
    input  logic [2:0]          AWPROT,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [3:0]          WID,
    input  logic [buswidth-1:0] WDATA,
    input  logic [3:0]          WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [3:0]          BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [AW_IDX-1:0]   rd_addr,
    output logic [buswidth-1:0] rd_data
);

    localparam logic [32:0] MEM_BYTES = 33'(MEMDEPTH * 4);

    wr_state_e           state_q, state_d;
    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic                bvalid_q, bvalid_d;
    logic [3:0]          awid_q, awid_d;
    logic [3:0]          awlen_q, awlen_d;
    logic [2:0]          awsize_q, awsize_d;
    logic [1:0]          awburst_q, awburst_d;
    logic [3:0]          beat_cnt_q, beat_cnt_d;
    logic [1:0]          resp_q, resp_d;
    logic                abort_q, abort_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         next_addr;
    logic [buswidth-1:0] rd_data_q;
    logic [buswidth-1:0] mem_q [MEMDEPTH];

    logic                wr_en;
    logic [AW_IDX-1:0]   wr_idx;
    logic [1:0]          aw_err;
    logic [32:0]         aw_bytes;
    logic [32:0]         aw_end;
    logic [31:0]         aw_align;
    logic                beat_fire;
    logic                last_beat;
    logic                id_bad;

    // Lock, cache and protection attributes carry no meaning for this memory.
    logic unused_attr;
    assign unused_attr = ^{AWLOCK, AWCACHE, AWPROT};

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = awid_q;
    assign BRESP   = resp_q;
    assign rd_data = rd_data_q;
    assign wr_idx  = addr_q[AW_IDX+1:2];

    axi_burst_addr_gen u_addr_gen (
        .cur_addr  (addr_q),
        .awsize    (awsize_q),
        .awlen     (awlen_q),
        .awburst   (awburst_q),
        .next_addr (next_addr)
    );

    // Burst-wide legality, decided once when the address is accepted.
    always_comb begin
        aw_err   = RESP_OKAY;
        aw_bytes = (33'(AWLEN) + 33'd1) << AWSIZE;
        aw_end   = {1'b0, AWADDR} + aw_bytes;
        aw_align = (32'd1 << AWSIZE) - 32'd1;
        if (AWBURST == 2'd3 || AWSIZE > 3'd2) begin
            aw_err = RESP_SLVERR;
        end
        if (AWBURST == BURST_WRAP &&
            (!(AWLEN inside {4'd1, 4'd3, 4'd7, 4'd15}) || (AWADDR & aw_align) != 32'd0)) begin
            aw_err = RESP_SLVERR;
        end
        if ({1'b0, AWADDR} >= MEM_BYTES) begin
            aw_err = RESP_DECERR;
        end else if (AWBURST == BURST_INCR && aw_end > MEM_BYTES) begin
            aw_err = RESP_DECERR;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        awid_d     = awid_q;
        awlen_d    = awlen_q;
        awsize_d   = awsize_q;
        awburst_d  = awburst_q;
        beat_cnt_d = beat_cnt_q;
        resp_d     = resp_q;
        abort_d    = abort_q;
        addr_d     = addr_q;
        wr_en      = 1'b0;
        beat_fire  = WVALID && wready_q;
        last_beat  = (beat_cnt_q == awlen_q);
        id_bad     = (WID != awid_q);

        case (state_q)
            IDLE: begin
                if (AWVALID && awready_q) begin
                    awid_d     = AWID;
                    awlen_d    = AWLEN;
                    awsize_d   = AWSIZE;
                    awburst_d  = AWBURST;
                    addr_d     = AWADDR;
                    beat_cnt_d = 4'd0;
                    resp_d     = aw_err;
                    abort_d    = (aw_err != RESP_OKAY);
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (beat_fire) begin
                    wr_en      = !abort_q && !id_bad;
                    // Early WLAST and missing WLAST both end the burst here.
                    if (id_bad || (WLAST != last_beat)) begin
                        resp_d = resp_merge(resp_q, RESP_SLVERR);
                    end
                    addr_d     = next_addr;
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    if (WLAST || last_beat) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (bvalid_q && BREADY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered copies of the next state.
        awready_d = (state_d == IDLE);
        wready_d  = (state_d == DATA);
        bvalid_d  = (state_d == RESP);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of the others; reset is synchronous.
    always_ff @(posedge devclock) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            awid_q     <= '0;
            awlen_q    <= '0;
            awsize_q   <= '0;
            awburst_q  <= '0;
            beat_cnt_q <= '0;
            resp_q     <= RESP_OKAY;
            abort_q    <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            awid_q     <= awid_d;
            awlen_q    <= awlen_d;
            awsize_q   <= awsize_d;
            awburst_q  <= awburst_d;
            beat_cnt_q <= beat_cnt_d;
            resp_q     <= resp_d;
            abort_q    <= abort_d;
            addr_q     <= addr_d;
        end
    end

    // NOTE: the memory is cleared by reset, which forces it into flops rather
    // than a RAM macro; this is intended, the contents must read back as zero.
    // The read samples mem_q before this edge's write, giving old-data reads.
    always_ff @(posedge devclock) begin
        if (!ARESETn) begin
            for (int i = 0; i < MEMDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
            if (wr_en) begin
                for (int k = 0; k < 4; k++) begin
                    if (WSTRB[k]) begin
                        mem_q[wr_idx][8*k +: 8] <= WDATA[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_write_slave.sv
// tb_axi_write_slave: directed self-checking bench for axi_write_slave.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_axi_write_slave;
    import axi_pkg::*;

    logic        devclock = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [1:0]  AWLOCK;
    logic [3:0]  AWCACHE;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [3:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 devclock = ~devclock;

    axi_write_slave #(.buswidth(32), .MEMDEPTH(64), .AW_IDX(6)) dut (
        .devclock (devclock),
        .ARESETn  (ARESETn),
        .AWID     (AWID),
        .AWADDR   (AWADDR),
        .AWLEN    (AWLEN),
        .AWSIZE   (AWSIZE),
        .AWBURST  (AWBURST),
        .AWLOCK   (AWLOCK),
        .AWCACHE  (AWCACHE),
        .AWPROT   (AWPROT),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WID      (WID),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WLAST    (WLAST),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BID      (BID),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    task automatic tick();
        @(posedge devclock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
        int n;
        AWID    = id;
        AWADDR  = addr;
        AWLEN   = len;
        AWSIZE  = 3'd2;
        AWBURST = burst;
        AWVALID = 1'b1;
        n = 0;
        while (AWREADY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("awready_wait", {31'd0, AWREADY}, 32'd1);
        tick();
        AWVALID = 1'b0;
        check("awready_low_after_aw", {31'd0, AWREADY}, 32'd0);
    endtask

    task automatic send_w(input logic [3:0] id, input logic [31:0] data,
                          input logic [3:0] strb, input logic last);
        int n;
        WID    = id;
        WDATA  = data;
        WSTRB  = strb;
        WLAST  = last;
        WVALID = 1'b1;
        n = 0;
        while (WREADY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("wready_wait", {31'd0, WREADY}, 32'd1);
        tick();
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic take_b(input string tag, input logic [3:0] exp_id, input logic [1:0] exp_resp);
        int n;
        n = 0;
        while (BVALID !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_bvalid"}, {31'd0, BVALID}, 32'd1);
        check({tag, "_bid"}, {28'd0, BID}, {28'd0, exp_id});
        check({tag, "_bresp"}, {30'd0, BRESP}, {30'd0, exp_resp});
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check({tag, "_bvalid_clear"}, {31'd0, BVALID}, 32'd0);
        check({tag, "_awready_back"}, {31'd0, AWREADY}, 32'd1);
    endtask

    task automatic check_word(input string tag, input logic [5:0] idx, input logic [31:0] exp);
        rd_addr = idx;
        tick();
        check(tag, rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = BURST_INCR;
        AWLOCK = '0; AWCACHE = '0; AWPROT = '0; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0; rd_addr = '0;

        // Reset state
        repeat (3) tick();
        check("rst_awready", {31'd0, AWREADY}, 32'd0);
        check("rst_wready", {31'd0, WREADY}, 32'd0);
        check("rst_bvalid", {31'd0, BVALID}, 32'd0);
        check("rst_bid", {28'd0, BID}, 32'd0);
        check("rst_bresp", {30'd0, BRESP}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        ARESETn = 1'b1;
        tick();
        check("rel_awready", {31'd0, AWREADY}, 32'd1);

        // INCR single beat to word 4
        send_aw(4'd3, 32'h10, 4'd0, BURST_INCR);
        check("single_wready", {31'd0, WREADY}, 32'd1);
        send_w(4'd3, 32'hDEADBEEF, 4'hF, 1'b1);
        check("single_bvalid_next", {31'd0, BVALID}, 32'd1);
        take_b("single", 4'd3, RESP_OKAY);
        check_word("single_mem4", 6'd4, 32'hDEADBEEF);

        // INCR 4 beats from 0x20, response held off for 5 cycles
        send_aw(4'd1, 32'h20, 4'd3, BURST_INCR);
        for (int i = 1; i <= 4; i++) begin
            send_w(4'd1, 32'(i), 4'hF, (i == 4));
        end
        AWADDR  = 32'h0;
        AWVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_bvalid", {31'd0, BVALID}, 32'd1);
            check("hold_bresp", {30'd0, BRESP}, 32'd0);
            check("hold_bid", {28'd0, BID}, 32'd1);
            check("hold_awready", {31'd0, AWREADY}, 32'd0);
            tick();
        end
        AWVALID = 1'b0;
        take_b("incr4", 4'd1, RESP_OKAY);
        check_word("incr4_mem8", 6'd8, 32'd1);
        check_word("incr4_mem9", 6'd9, 32'd2);
        check_word("incr4_mem10", 6'd10, 32'd3);
        check_word("incr4_mem11", 6'd11, 32'd4);

        // WRAP 4 beats from 0x38: words 14,15,12,13
        send_aw(4'd2, 32'h38, 4'd3, BURST_WRAP);
        for (int i = 0; i < 4; i++) begin
            send_w(4'd2, 32'hA0 + 32'(i), 4'hF, (i == 3));
        end
        take_b("wrap", 4'd2, RESP_OKAY);
        check_word("wrap_mem14", 6'd14, 32'hA0);
        check_word("wrap_mem15", 6'd15, 32'hA1);
        check_word("wrap_mem12", 6'd12, 32'hA2);
        check_word("wrap_mem13", 6'd13, 32'hA3);

        // Misaligned WRAP: SLVERR, nothing written
        send_aw(4'd2, 32'h39, 4'd3, BURST_WRAP);
        for (int i = 0; i < 4; i++) begin
            send_w(4'd2, 32'hB0 + 32'(i), 4'hF, (i == 3));
        end
        take_b("wrap_bad", 4'd2, RESP_SLVERR);
        check_word("wrap_bad_mem14", 6'd14, 32'hA0);
        check_word("wrap_bad_mem12", 6'd12, 32'hA2);

        // Byte strobes on word 2
        send_aw(4'd0, 32'h8, 4'd0, BURST_INCR);
        send_w(4'd0, 32'hFFFFFFFF, 4'hF, 1'b1);
        take_b("strb_fill", 4'd0, RESP_OKAY);
        send_aw(4'd0, 32'h8, 4'd0, BURST_INCR);
        send_w(4'd0, 32'h12345678, 4'h5, 1'b1);
        take_b("strb_part", 4'd0, RESP_OKAY);
        check_word("strb_mem2", 6'd2, 32'hFF34FF78);

        // FIXED burst: both beats land on word 20
        send_aw(4'd1, 32'h50, 4'd1, BURST_FIXED);
        send_w(4'd1, 32'h1, 4'hF, 1'b0);
        send_w(4'd1, 32'h2, 4'hF, 1'b1);
        take_b("fixed", 4'd1, RESP_OKAY);
        check_word("fixed_mem20", 6'd20, 32'h2);
        check_word("fixed_mem21", 6'd21, 32'h0);

        // Out-of-range address: DECERR, nothing written
        send_aw(4'd3, 32'h100, 4'd0, BURST_INCR);
        send_w(4'd3, 32'h55, 4'hF, 1'b1);
        take_b("decerr", 4'd3, RESP_DECERR);
        check_word("decerr_mem0", 6'd0, 32'h0);

        // WID mismatch: SLVERR, word 1 untouched
        send_aw(4'd3, 32'h4, 4'd0, BURST_INCR);
        send_w(4'd5, 32'h66, 4'hF, 1'b1);
        take_b("wid_bad", 4'd3, RESP_SLVERR);
        check_word("wid_bad_mem1", 6'd1, 32'h0);

        // Early WLAST on beat 1 of a 4-beat burst
        send_aw(4'd6, 32'h40, 4'd3, BURST_INCR);
        send_w(4'd6, 32'h11, 4'hF, 1'b0);
        send_w(4'd6, 32'h22, 4'hF, 1'b1);
        check("early_last_bvalid", {31'd0, BVALID}, 32'd1);
        check("early_last_wready", {31'd0, WREADY}, 32'd0);
        take_b("early_last", 4'd6, RESP_SLVERR);
        check_word("early_last_mem16", 6'd16, 32'h11);

        // Final beat without WLAST
        send_aw(4'd7, 32'h48, 4'd0, BURST_INCR);
        send_w(4'd7, 32'h99, 4'hF, 1'b0);
        check("no_last_bvalid", {31'd0, BVALID}, 32'd1);
        take_b("no_last", 4'd7, RESP_SLVERR);

        // Reset during beat 2 of a 4-beat burst
        send_aw(4'd4, 32'h60, 4'd3, BURST_INCR);
        send_w(4'd4, 32'h70, 4'hF, 1'b0);
        send_w(4'd4, 32'h71, 4'hF, 1'b0);
        WID = 4'd4; WDATA = 32'h72; WSTRB = 4'hF; WVALID = 1'b1;
        ARESETn = 1'b0;
        tick();
        WVALID = 1'b0;
        check("midrst_bvalid", {31'd0, BVALID}, 32'd0);
        check("midrst_wready", {31'd0, WREADY}, 32'd0);
        check("midrst_awready", {31'd0, AWREADY}, 32'd0);
        tick();
        ARESETn = 1'b1;
        tick();
        check("midrst_rel_awready", {31'd0, AWREADY}, 32'd1);
        check("midrst_rel_bvalid", {31'd0, BVALID}, 32'd0);
        check_word("midrst_mem24", 6'd24, 32'h0);
        check_word("midrst_mem25", 6'd25, 32'h0);
        check_word("midrst_mem26", 6'd26, 32'h0);
        check_word("midrst_mem4", 6'd4, 32'h0);
        check_word("midrst_mem2", 6'd2, 32'h0);
        check_word("midrst_mem14", 6'd14, 32'h0);
        check("midrst_no_b", {31'd0, BVALID}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
